fpu_mult_arb: RTL

FPU_MULT_ARB -- requirements
Module: fpu_mult_arb

---
 rtl/fpu_mult_arb_if.sv | 22 ++
 rtl/fpu_mult_arb.sv | 84 ++++++++
 2 files changed

// File: rtl/fpu_mult_arb_if.sv
// fpu_mult_arb_if: requester, response and shared-multiplier signal bundle
interface fpu_mult_arb_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        mul_en;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_result;
    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_result,
        input  req_ready, rsp_valid, rsp_result, mul_en, mul_a, mul_b
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_result,
        output req_ready, rsp_valid, rsp_result, mul_en, mul_a, mul_b
    );
endinterface

// File: rtl/fpu_mult_arb.sv
// fpu_mult_arb: two-requester round-robin arbiter in front of one shared FP multiplier
module fpu_mult_arb #(
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_mult_arb_if.slave bus,
    output logic          busy,
    output logic [15:0]   op_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        prio_q, prio_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic [15:0] ops_q, ops_d;
    logic        g;
    assign g = (bus.req_valid == 2'b11) ? prio_q : bus.req_valid[1];
    assign bus.req_ready = (state_q == IDLE && rst_n && |bus.req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_result = res_q;
    assign bus.mul_en = state_q == WAIT;
    assign bus.mul_a = a_q;
    assign bus.mul_b = b_q;
    assign busy = state_q != IDLE;
    assign op_count = ops_q;
    // Next state: accept in IDLE, count down latency in WAIT, hand off in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: if (|bus.req_valid) begin
                a_d     = g ? bus.req_a[63:32] : bus.req_a[31:0];
                b_d     = g ? bus.req_b[63:32] : bus.req_b[31:0];
                gnt_d   = g;
                cnt_d   = 4'(LAT);
                state_d = WAIT;
            end
            WAIT: if (cnt_q == 4'd0) begin
                res_d   = bus.mul_result;
                state_d = RESP;
            end else begin
                cnt_d   = cnt_q - 4'd1;
            end
            RESP: if (bus.rsp_ready[gnt_q]) begin
                prio_d  = ~gnt_q;
                ops_d   = &ops_q ? ops_q : ops_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State register with synchronous active-low reset discarding any in-flight op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            ops_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ops_q   <= ops_d;
        end
    end
endmodule
